// File: rtl/difftest_snapshot_csr_restore_pkg.sv
// -----------------------------------------------------------------------------
// difftest_snapshot_pkg
// Shared definitions for the difftest CSR snapshot restore block: FSM state
// encoding, packet magic, target CSR addresses, error codes and the number of
// payload beats that follow a header.
// Optional feature macro: DIFFTEST_SNAPSHOT_CHECKSUM_EN (adds a checksum beat).
// -----------------------------------------------------------------------------
package difftest_snapshot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_RECV        = 2'd1,
      ST_WR_MINSTRET = 2'd2,
      ST_WR_MCYCLE   = 2'd3
   } state_e;

   localparam logic [15:0] SNAP_MAGIC   = 16'hC5A7;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_HEADER   = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // Payload beats following the header: minstret lo/hi, mcycle lo/hi and,
   // when enabled, one checksum beat.
   function automatic logic [2:0] payload_beats();
`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
      return 3'd5;
`else
      return 3'd4;
`endif
   endfunction

endpackage

// File: rtl/difftest_snapshot_csr_restore_if.sv
// -----------------------------------------------------------------------------
// difftest_snapshot_csr_restore_if
// Bundles the restore-beat channel (in_valid/in_ready/in_data) and the CSR
// write port (csr_wen/csr_addr/csr_wdata/csr_ack).
//   slave  : restore block view (consumes beats, drives CSR writes)
//   master : environment view (host channel + CSR file)
// -----------------------------------------------------------------------------
interface difftest_snapshot_csr_restore_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        csr_wen;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata;
   logic        csr_ack;

   modport slave (
      input  in_valid, in_data, csr_ack,
      output in_ready, csr_wen, csr_addr, csr_wdata
   );

   modport master (
      output in_valid, in_data, csr_ack,
      input  in_ready, csr_wen, csr_addr, csr_wdata
   );
endinterface

// File: rtl/difftest_snapshot_csr_restore.sv
// -----------------------------------------------------------------------------
// difftest_snapshot_csr_restore
// Receives a serialized CSR snapshot (header, minstret lo/hi, mcycle lo/hi and
// optionally a checksum) as 32-bit beats and writes minstret (0xB02) then
// mcycle (0xB00) into the core CSR file over a write/ack handshake.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   bus (slave)     : restore beats in, CSR write request/ack
//   busy            : packet in progress (state != IDLE)
//   done            : one-cycle pulse after the mcycle write is acked
//   err, err_code   : sticky error flag and cause (1 header, 2 checksum,
//                     3 ack timeout); cleared by the next valid header
// Optional feature macro: DIFFTEST_SNAPSHOT_CHECKSUM_EN
// -----------------------------------------------------------------------------
module difftest_snapshot_csr_restore
   import difftest_snapshot_pkg::*;
#(
   parameter logic [7:0]  COREID         = 8'd0,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   difftest_snapshot_csr_restore_if.slave       bus,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err,
   output logic [1:0]                           err_code
);

   localparam logic [1:0]  S_IDLE        = ST_IDLE;
   localparam logic [1:0]  S_RECV        = ST_RECV;
   localparam logic [1:0]  S_WR_MINSTRET = ST_WR_MINSTRET;
   localparam logic [1:0]  S_WR_MCYCLE   = ST_WR_MCYCLE;
   localparam logic [2:0]  LAST_BEAT     = payload_beats() - 3'd1;
   // The wait counter times out on the cycle its increment would reach
   // TIMEOUT_CYCLES, so the write is presented for exactly TIMEOUT_CYCLES cycles.
   localparam logic [15:0] WAIT_LAST     = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [2:0]  r_beat_cnt;
   logic [63:0] r_minstret;
   logic [63:0] r_mcycle;
   logic [15:0] r_wait_cnt;
   logic        r_done;
   logic        r_err;
   logic [1:0]  r_err_code;

   logic        w_beat;
   logic        w_hdr_ok;

   assign w_beat   = bus.in_valid && bus.in_ready;
   assign w_hdr_ok = (bus.in_data[31:16] == SNAP_MAGIC) && (bus.in_data[7:0] == COREID);

`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
   // All four payload words are already staged when the checksum beat arrives.
   logic [31:0] w_csum;
   assign w_csum = r_minstret[31:0] ^ r_minstret[63:32] ^ r_mcycle[31:0] ^ r_mcycle[63:32];
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_beat_cnt <= 3'd0;
         r_minstret <= 64'd0;
         r_mcycle   <= 64'd0;
         r_wait_cnt <= 16'd0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_beat) begin
                  if (w_hdr_ok) begin
                     r_err      <= 1'b0;
                     r_err_code <= ERR_NONE;
                     r_beat_cnt <= 3'd0;
                     r_state    <= S_RECV;
                  end else begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_HEADER;
                  end
               end
            end
            S_RECV: begin
               if (w_beat) begin
                  case (r_beat_cnt)
                     3'd0:    r_minstret[31:0]  <= bus.in_data;
                     3'd1:    r_minstret[63:32] <= bus.in_data;
                     3'd2:    r_mcycle[31:0]    <= bus.in_data;
                     3'd3:    r_mcycle[63:32]   <= bus.in_data;
                     default: ;
                  endcase
                  r_beat_cnt <= r_beat_cnt + 3'd1;
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_wait_cnt <= 16'd0;
`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
                     if (bus.in_data != w_csum) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_CHECKSUM;
                        r_state    <= S_IDLE;
                     end else begin
                        r_state    <= S_WR_MINSTRET;
                     end
`else
                     r_state <= S_WR_MINSTRET;
`endif
                  end
               end
            end
            S_WR_MINSTRET, S_WR_MCYCLE: begin
               // Ack takes priority over a timeout in the same cycle.
               if (bus.csr_ack) begin
                  r_wait_cnt <= 16'd0;
                  if (r_state == S_WR_MINSTRET) begin
                     r_state <= S_WR_MCYCLE;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
                  r_state    <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      bus.in_ready  = (r_state == S_IDLE) || (r_state == S_RECV);
      bus.csr_wen   = 1'b0;
      bus.csr_addr  = 12'd0;
      bus.csr_wdata = 64'd0;
      if (r_state == S_WR_MINSTRET) begin
         bus.csr_wen   = 1'b1;
         bus.csr_addr  = CSR_MINSTRET;
         bus.csr_wdata = r_minstret;
      end else if (r_state == S_WR_MCYCLE) begin
         bus.csr_wen   = 1'b1;
         bus.csr_addr  = CSR_MCYCLE;
         bus.csr_wdata = r_mcycle;
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign err      = r_err;
   assign err_code = r_err_code;

endmodule

// File: tb/tb_difftest_snapshot_csr_restore.sv
// -----------------------------------------------------------------------------
// tb_difftest_snapshot_csr_restore
// Self-checking bench for difftest_snapshot_csr_restore (COREID=0,
// TIMEOUT_CYCLES=4). Honours DIFFTEST_SNAPSHOT_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_difftest_snapshot_csr_restore;

   localparam int T_OUT = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       busy, done, err;
   logic [1:0] err_code;

   int total = 0;
   int bad   = 0;

   // Observations from the CSR side, taken on the falling edge.
   logic [11:0] mon_addr[$];
   logic [63:0] mon_data[$];
   int          mon_done = 0;
   int          mon_wen  = 0;

   difftest_snapshot_csr_restore_if bus_if ();

   difftest_snapshot_csr_restore #(
      .COREID         (8'd0),
      .TIMEOUT_CYCLES (T_OUT)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus_if.slave),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (bus_if.csr_wen) mon_wen++;
      if (bus_if.csr_wen && bus_if.csr_ack) begin
         mon_addr.push_back(bus_if.csr_addr);
         mon_data.push_back(bus_if.csr_wdata);
      end
      if (done) mon_done++;
   end

   task automatic clear_mon();
      mon_addr.delete();
      mon_data.delete();
      mon_done = 0;
      mon_wen  = 0;
   endtask

   task automatic send_beat(input logic [31:0] d, input bit gaps);
      int n;
      if (gaps) begin
         n = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) begin
            bus_if.in_valid = 1'b0;
            bus_if.in_data  = $urandom;
            bus_if.csr_ack  = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
         end
      end
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      @(posedge clock); #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] cid, input logic [63:0] mi, input logic [63:0] mc, input bit gaps);
      send_beat({16'hC5A7, 8'h00, cid}, gaps);
      send_beat(mi[31:0], gaps);
      send_beat(mi[63:32], gaps);
      send_beat(mc[31:0], gaps);
      send_beat(mc[63:32], gaps);
   endtask

`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
   task automatic send_csum(input logic [63:0] mi, input logic [63:0] mc, input logic [31:0] off, input bit gaps);
      logic [31:0] x;
      x = mi[31:0] ^ mi[63:32] ^ mc[31:0] ^ mc[63:32];
      send_beat(x + off, gaps);
   endtask
`endif

   task automatic send_full(input logic [63:0] mi, input logic [63:0] mc, input bit gaps);
      send_packet(8'h00, mi, mc, gaps);
`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
      send_csum(mi, mc, 32'd0, gaps);
`endif
   endtask

   // CSR-file model: acks write k after delay dk cycles of csr_wen.
   task automatic ack_driver(input int d0, input int d1, input int ncyc);
      int w = 0;
      int c = 0;
      bit was;
      for (int i = 0; i < ncyc; i++) begin
         was = bus_if.csr_wen;
         bus_if.csr_ack = was && (c == ((w == 0) ? d0 : d1));
         @(posedge clock); #1;
         if (bus_if.csr_ack) begin w++; c = 0; end
         else if (was) c++;
      end
      bus_if.csr_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = 32'd0;
      bus_if.csr_ack  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); end
      total++; if (bus_if.csr_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", bus_if.csr_wen); end
      total++; if (bus_if.csr_addr !== 12'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus_if.csr_addr); end
      total++; if (bus_if.csr_wdata !== 64'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus_if.csr_wdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
      reset_n = 1'b1;
      @(posedge clock); #1;
      $display("txn reset released");
   endtask

   task automatic test_basic();
      logic [63:0] mi, mc;
      mi = 64'h0000_0001_0000_0010;
      mc = 64'h0000_0002_0000_0020;
      clear_mon();
      bus_if.csr_ack = 1'b1;   // tied high, also while idle/receiving
      send_beat({16'hC5A7, 16'h0000}, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_recv got=%b exp=1", busy); end
      send_beat(mi[31:0], 1'b0);
      send_beat(mi[63:32], 1'b0);
      send_beat(mc[31:0], 1'b0);
      send_beat(mc[63:32], 1'b0);
`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
      send_csum(mi, mc, 32'd0, 1'b0);
`endif
      total++; if (bus_if.csr_wen !== 1'b1) begin bad++; $display("FAIL basic_wen1 got=%b exp=1", bus_if.csr_wen); end
      total++; if (bus_if.csr_addr !== 12'hB02) begin bad++; $display("FAIL basic_addr1 got=%h exp=b02", bus_if.csr_addr); end
      total++; if (bus_if.csr_wdata !== mi) begin bad++; $display("FAIL basic_data1 got=%h exp=%h", bus_if.csr_wdata, mi); end
      total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_wr got=%b exp=0", bus_if.in_ready); end
      @(posedge clock); #1;
      total++; if (bus_if.csr_addr !== 12'hB00) begin bad++; $display("FAIL basic_addr2 got=%h exp=b00", bus_if.csr_addr); end
      total++; if (bus_if.csr_wdata !== mc) begin bad++; $display("FAIL basic_data2 got=%h exp=%h", bus_if.csr_wdata, mc); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b exp=0", done); end
      @(posedge clock); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
      total++; if (bus_if.csr_wen !== 1'b0) begin bad++; $display("FAIL basic_wen_after got=%b exp=0", bus_if.csr_wen); end
      total++; if (bus_if.csr_wdata !== 64'd0) begin bad++; $display("FAIL basic_wdata_idle got=%h exp=0", bus_if.csr_wdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
      @(posedge clock); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      total++; if (mon_wen !== 2) begin bad++; $display("FAIL basic_wen_cycles got=%0d exp=2", mon_wen); end
      bus_if.csr_ack = 1'b0;
      $display("txn basic mi=%h mc=%h", mi, mc);
   endtask

   task automatic test_bad_header();
      logic [63:0] mi, mc;
      mi = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      clear_mon();
      send_beat(32'hC5A7_0003, 1'b0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL badhdr_err got=%b exp=1", err); end
      total++; if (err_code !== 2'd1) begin bad++; $display("FAIL badhdr_code got=%0d exp=1", err_code); end
      total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL badhdr_in_ready got=%b exp=1", bus_if.in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL badhdr_busy got=%b exp=0", busy); end
      send_beat(32'h1234_0000, 1'b0);
      total++; if (err_code !== 2'd1) begin bad++; $display("FAIL badmagic_code got=%0d exp=1", err_code); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL badmagic_busy got=%b exp=0", busy); end
      repeat (3) @(posedge clock);
      #1;
      total++; if (mon_wen !== 0) begin bad++; $display("FAIL badhdr_no_wen got=%0d exp=0", mon_wen); end
      send_full(mi, mc, 1'b0);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL badhdr_cleared got=%b exp=0", err); end
      total++; if (err_code !== 2'd0) begin bad++; $display("FAIL badhdr_code_cleared got=%0d exp=0", err_code); end
      ack_driver(0, 0, 6);
      total++; if (mon_done !== 1) begin bad++; $display("FAIL badhdr_recover_done got=%0d exp=1", mon_done); end
      $display("txn bad_header then valid mi=%h mc=%h", mi, mc);
   endtask

   task automatic test_timeout();
      logic [63:0] mi, mc;
      mi = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      // first write never acked
      clear_mon();
      send_full(mi, mc, 1'b0);
      ack_driver(T_OUT, 0, 10);
      total++; if (mon_wen !== T_OUT) begin bad++; $display("FAIL to1_wen_cycles got=%0d exp=%0d", mon_wen, T_OUT); end
      total++; if (mon_addr.size() !== 0) begin bad++; $display("FAIL to1_writes got=%0d exp=0", mon_addr.size()); end
      total++; if (err_code !== 2'd3 || err !== 1'b1) begin bad++; $display("FAIL to1_err got=%b/%0d exp=1/3", err, err_code); end
      total++; if (mon_done !== 0) begin bad++; $display("FAIL to1_done got=%0d exp=0", mon_done); end
      total++; if (busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL to1_idle got=%b/%b exp=0/1", busy, bus_if.in_ready); end
      $display("txn timeout on minstret write");
      // second write never acked
      clear_mon();
      send_full(mi, mc, 1'b0);
      ack_driver(0, T_OUT + 1, 12);
      total++; if (mon_wen !== T_OUT + 1) begin bad++; $display("FAIL to2_wen_cycles got=%0d exp=%0d", mon_wen, T_OUT + 1); end
      total++; if (mon_addr.size() !== 1) begin bad++; $display("FAIL to2_writes got=%0d exp=1", mon_addr.size()); end
      total++; if (err_code !== 2'd3) begin bad++; $display("FAIL to2_code got=%0d exp=3", err_code); end
      total++; if (mon_done !== 0) begin bad++; $display("FAIL to2_done got=%0d exp=0", mon_done); end
      $display("txn timeout on mcycle write");
      // ack on the last allowed cycle wins over the timeout
      clear_mon();
      send_full(mi, mc, 1'b0);
      ack_driver(T_OUT - 1, T_OUT - 1, 12);
      total++; if (mon_addr.size() !== 2) begin bad++; $display("FAIL to3_writes got=%0d exp=2", mon_addr.size()); end
      total++; if (mon_done !== 1) begin bad++; $display("FAIL to3_done got=%0d exp=1", mon_done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL to3_err got=%b exp=0", err); end
      $display("txn ack on timeout boundary");
   endtask

`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
   task automatic test_checksum();
      logic [63:0] mi, mc;
      mi = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      clear_mon();
      send_packet(8'h00, mi, mc, 1'b0);
      send_csum(mi, mc, 32'd1, 1'b0);
      total++; if (err !== 1'b1 || err_code !== 2'd2) begin bad++; $display("FAIL csum_err got=%b/%0d exp=1/2", err, err_code); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL csum_busy got=%b exp=0", busy); end
      ack_driver(0, 0, 5);
      total++; if (mon_wen !== 0) begin bad++; $display("FAIL csum_no_wen got=%0d exp=0", mon_wen); end
      $display("txn bad checksum");
      clear_mon();
      send_full(mi, mc, 1'b0);
      ack_driver(0, 0, 6);
      total++; if (mon_data.size() !== 2 || mon_data[0] !== mi || mon_data[1] !== mc) begin bad++; $display("FAIL csum_good_data n=%0d exp=2 mi=%h mc=%h", mon_data.size(), mi, mc); end
      total++; if (err !== 1'b0 || mon_done !== 1) begin bad++; $display("FAIL csum_good_done got=%b/%0d exp=0/1", err, mon_done); end
      $display("txn good checksum mi=%h mc=%h", mi, mc);
   endtask
`endif

   task automatic test_reset_mid();
      logic [63:0] mi, mc;
      mi = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      clear_mon();
      send_beat({16'hC5A7, 16'h0000}, 1'b0);
      send_beat(mi[31:0], 1'b0);
      send_beat(mi[63:32], 1'b0);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = mc[31:0];
      #2 reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", bus_if.in_ready); end
      total++; if (bus_if.csr_wen !== 1'b0 || bus_if.csr_wdata !== 64'd0) begin bad++; $display("FAIL rstmid_csr got=%b/%h exp=0/0", bus_if.csr_wen, bus_if.csr_wdata); end
      total++; if (err !== 1'b0 || err_code !== 2'd0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_status got=%b/%0d/%b exp=0/0/0", err, err_code, done); end
      bus_if.in_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      $display("txn reset during receive");
      // reset during a write
      send_full(mi, mc, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      total++; if (bus_if.csr_wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstwr_idle got=%b/%b exp=0/0", bus_if.csr_wen, busy); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      total++; if (mon_addr.size() !== 0 || mon_done !== 0) begin bad++; $display("FAIL rstwr_nowrite got=%0d/%0d exp=0/0", mon_addr.size(), mon_done); end
      $display("txn reset during write");
      // full packet afterwards
      mi = {$urandom, $urandom};
      mc = {$urandom, $urandom};
      clear_mon();
      send_full(mi, mc, 1'b0);
      ack_driver(1, 2, 12);
      total++; if (mon_data.size() !== 2 || mon_data[0] !== mi || mon_data[1] !== mc) begin bad++; $display("FAIL rstpost_data n=%0d exp=2 mi=%h mc=%h", mon_data.size(), mi, mc); end
      total++; if (mon_done !== 1) begin bad++; $display("FAIL rstpost_done got=%0d exp=1", mon_done); end
      $display("txn restore after reset mi=%h mc=%h", mi, mc);
   endtask

   task automatic test_random();
      logic [63:0] mi, mc;
      logic [7:0]  cid;
      int d0, d1;
      for (int p = 0; p < 25; p++) begin
         mi = {$urandom, $urandom};
         mc = {$urandom, $urandom};
         d0 = $urandom_range(0, 3);
         d1 = $urandom_range(0, 3);
         clear_mon();
         if ($urandom_range(0, 3) == 0) begin
            cid = 8'($urandom_range(1, 255));
            send_beat({16'hC5A7, 8'h00, cid}, 1'b1);
            total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL rnd_badhdr p=%0d got=%b/%0d exp=1/1", p, err, err_code); end
         end
         send_full(mi, mc, 1'b1);
         ack_driver(d0, d1, 12);
         total++; if (mon_addr.size() !== 2) begin bad++; $display("FAIL rnd_nwrites p=%0d got=%0d exp=2", p, mon_addr.size()); end
         total++; if (mon_addr[0] !== 12'hB02 || mon_addr[1] !== 12'hB00) begin bad++; $display("FAIL rnd_addr p=%0d got=%h,%h exp=b02,b00", p, mon_addr[0], mon_addr[1]); end
         total++; if (mon_data[0] !== mi) begin bad++; $display("FAIL rnd_minstret p=%0d got=%h exp=%h", p, mon_data[0], mi); end
         total++; if (mon_data[1] !== mc) begin bad++; $display("FAIL rnd_mcycle p=%0d got=%h exp=%h", p, mon_data[1], mc); end
         total++; if (mon_wen !== d0 + d1 + 2) begin bad++; $display("FAIL rnd_wen_cycles p=%0d got=%0d exp=%0d", p, mon_wen, d0 + d1 + 2); end
         total++; if (mon_done !== 1 || err !== 1'b0) begin bad++; $display("FAIL rnd_done p=%0d got=%0d/%b exp=1/0", p, mon_done, err); end
         $display("txn rnd %0d mi=%h mc=%h d0=%0d d1=%0d", p, mi, mc, d0, d1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_header();
      test_timeout();
`ifdef DIFFTEST_SNAPSHOT_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
